// File: rtl/booth_radix4_multiplier_if.sv
// Start/done handshake bundle for the radix-4 Booth multiplier.
// The master drives the request and operands; the slave returns status and the product.
interface booth_radix4_multiplier_if #(
  parameter int N = 8
);
  logic                  start;
  logic signed [N-1:0]   multiplicand;
  logic signed [N-1:0]   multiplier;
  logic                  busy;
  logic                  done;
  logic signed [2*N-1:0] product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_radix4_multiplier.sv
// Sequential signed multiplier using radix-4 Booth recoding.
// It retires one Booth digit per clock, so a product takes N/2 cycles after acceptance.
module booth_radix4_multiplier #(
  parameter int N = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  booth_radix4_multiplier_if.slave      bus
);
  localparam int W      = 2 * N;
  localparam int DIGITS = N / 2;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, CALC} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q;      // multiplicand, pre-shifted by 2i
  logic [N:0]      b_q;      // {B, 1'b0}, shifted right by 2i
  logic [W-1:0]    acc_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    prod_q;
  logic            done_q;

  logic            accept;
  logic            finish;
  logic            last;
  logic [W-1:0]    pp;
  logic [W-1:0]    acc_sum;

  assign last = (cnt_q == CW'(DIGITS - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path through the
  // case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CALC;
          accept  = 1'b1;
        end
      end
      CALC: begin
        if (last) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The low three bits of b_q are the current triplet {B[2i+1], B[2i], B[2i-1]}.
  always_comb begin
    pp = '0;
    case (b_q[2:0])
      3'b001, 3'b010: pp = a_q;
      3'b011:         pp = a_q << 1;
      3'b100:         pp = -(a_q << 1);
      3'b101, 3'b110: pp = -a_q;
      default:        pp = '0;
    endcase
  end

  assign acc_sum = acc_q + pp;

  // NOTE: the datapath registers are plain flops, not a memory array, so they
  // are reset like any other state; this also clears product on an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        a_q   <= {{N{bus.multiplicand[N-1]}}, bus.multiplicand};
        b_q   <= {bus.multiplier, 1'b0};
        acc_q <= '0;
        cnt_q <= '0;
      end else if (state_q == CALC) begin
        a_q   <= a_q << 2;
        b_q   <= b_q >> 2;
        acc_q <= acc_sum;
        cnt_q <= cnt_q + CW'(1);
      end
      if (finish) prod_q <= acc_sum;
    end
  end

  assign bus.busy    = (state_q == CALC);
  assign bus.done    = done_q;
  assign bus.product = prod_q;
endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Self-checking bench for booth_radix4_multiplier: a cycle-level behavioural model
// compared every cycle, plus directed operations with literal expected products.
module tb_booth_radix4_multiplier;
  localparam int N = 8;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  booth_radix4_multiplier_if #(.N(N)) bus ();

  booth_radix4_multiplier #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: an accepted request yields a*b exactly N/2 edges later.
  logic                  m_busy = 1'b0;
  logic                  m_done = 1'b0;
  logic signed [2*N-1:0] m_prod = '0;
  logic signed [2*N-1:0] m_pending = '0;
  int                    m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_prod <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_prod <= m_pending;
        end
        m_left <= m_left - 1;
      end else if (bus.start) begin
        m_busy    <= 1'b1;
        m_left    <= N / 2;
        m_pending <= $signed(bus.multiplicand) * $signed(bus.multiplier);
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_busy", 64'(bus.busy), 64'(m_busy));
    check("cmp_done", 64'(bus.done), 64'(m_done));
    check("cmp_product", bus.product, m_prod);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Called #1 after a rising edge with the DUT idle (possibly in its done cycle).
  // Returns #1 after the completing edge, i.e. inside the done cycle.
  task automatic do_op(input logic signed [N-1:0] a, input logic signed [N-1:0] b,
                       input logic signed [2*N-1:0] exp, input string name);
    int cyc;
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(posedge clk); #1;
    bus.start        = 1'b0;
    bus.multiplicand = N'($urandom);
    bus.multiplier   = N'($urandom);
    cyc = 0;
    while (!bus.done && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_latency"}, 64'(cyc), 64'(N / 2));
    check({name, "_product"}, bus.product, exp);
    check({name, "_busy_low"}, 64'(bus.busy), 64'(0));
  endtask

  initial begin
    logic signed [N-1:0]   ra, rb;
    logic signed [2*N-1:0] held;
    int                    seen;
    int                    t_done [$];

    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    rst_n            = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_done", 64'(bus.done), 64'(0));
    check("reset_product", bus.product, 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Sign combinations
    do_op(8'sd5, 8'sd3, 16'sd15, "p5x3");
    do_op(-8'sd5, 8'sd3, -16'sd15, "n5x3");
    do_op(8'sd5, -8'sd3, -16'sd15, "p5xn3");
    do_op(-8'sd5, -8'sd3, 16'sd15, "n5xn3");

    // Back-to-back: new start issued in the done cycle of the previous result
    check("b2b_prev_done", 64'(bus.done), 64'(1));
    check("b2b_prev_product", bus.product, 16'sd15);
    do_op(8'sd3, -8'sd4, -16'sd12, "b2b_3xn4");

    // Recoding coverage
    do_op(8'sd12, 8'sd7, 16'sd84, "p12x7");
    do_op(-8'sd8, 8'sd4, -16'sd32, "n8x4");
    do_op(8'sd127, 8'sd2, 16'sd254, "p127x2");
    do_op(8'sh80, -8'sd1, 16'sh0080, "min_xn1");
    do_op(8'sh80, 8'sh80, 16'sh4000, "min_xmin");
    do_op(8'sd0, -8'sd77, 16'sd0, "zero_xn77");

    // Reset two cycles into CALC
    @(posedge clk); #1;
    bus.start        = 1'b1;
    bus.multiplicand = 8'sd9;
    bus.multiplier   = 8'sd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    check("abort_product", bus.product, 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'(0));
    do_op(8'sd6, 8'sd6, 16'sd36, "p6x6_after_reset");

    // Hold: product stable, no done while idle
    held = bus.product;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    check("hold_product", bus.product, held);
    check("hold_no_done", 64'(seen), 64'(0));
    check("hold_product_value", bus.product, 16'sd36);

    // start held high: one result every N/2+1 cycles
    bus.start        = 1'b1;
    bus.multiplicand = 8'sd7;
    bus.multiplier   = -8'sd9;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        t_done.push_back(k);
        check("held_product", bus.product, -16'sd63);
      end
    end
    bus.start = 1'b0;
    check("held_count", 64'(t_done.size()), 64'(3));
    if (t_done.size() == 3) begin
      check("held_first", 64'(t_done[0]), 64'(N / 2));
      check("held_gap1", 64'(t_done[1] - t_done[0]), 64'(N / 2 + 1));
      check("held_gap2", 64'(t_done[2] - t_done[1]), 64'(N / 2 + 1));
    end

    // Randomized operations with idle gaps
    @(posedge clk); #1;
    repeat (60) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      ra = N'($urandom);
      rb = N'($urandom);
      do_op(ra, rb, (2*N)'(int'(ra) * int'(rb)), "random");
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
